// File: rtl/wrr_bus_arbiter_pkg.sv
// Shared types and constants for the weighted round-robin bus arbiter.
package arb_pkg;

   localparam int unsigned NUM_MST = 4;
   localparam int unsigned IDX_W   = 2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY   = 2'd1,
      SWITCH = 2'd2
   } state_e;

   // Pointer starts at the last master so master 0 has first priority.
   localparam logic [IDX_W-1:0] PTR_RST = 2'd3;

   function automatic logic [NUM_MST-1:0] idx2oh(input logic [IDX_W-1:0] idx);
      return NUM_MST'(1) << idx;
   endfunction

endpackage

// File: rtl/wrr_bus_arbiter_if.sv
// Request/grant bundle between the four bus masters, the slave side and the arbiter.
// master: requester/slave-response side; slave: the arbiter itself.
interface wrr_bus_arbiter_if;

   logic       cyc0;
   logic       cyc1;
   logic       cyc2;
   logic       cyc3;
   logic       ack;
   logic [1:0] gnt;
   logic       gnt0;
   logic       gnt1;
   logic       gnt2;
   logic       gnt3;
   logic       comcyc;

   modport master (
      output cyc0, cyc1, cyc2, cyc3, ack,
      input  gnt, gnt0, gnt1, gnt2, gnt3, comcyc
   );

   modport slave (
      input  cyc0, cyc1, cyc2, cyc3, ack,
      output gnt, gnt0, gnt1, gnt2, gnt3, comcyc
   );

endinterface

// File: rtl/wrr_bus_arbiter_rr_pick.sv
// Combinational rotate-priority picker: first asserted req in order last+1 .. last+4.
module rr_pick
   import arb_pkg::*;
(
   input  logic [NUM_MST-1:0] req,
   input  logic [IDX_W-1:0]   last,
   output logic               valid,
   output logic [IDX_W-1:0]   idx
);

   logic [IDX_W-1:0] cand;

   // Scan from farthest to nearest so the nearest requester wins.
   always_comb begin
      valid = |req;
      idx   = '0;
      cand  = '0;
      for (int k = NUM_MST; k >= 1; k--) begin
         cand = last + IDX_W'(k);
         if (req[cand]) begin
            idx = cand;
         end
      end
   end

endmodule

// File: rtl/wrr_bus_arbiter.sv
// Weighted round-robin arbiter: four masters share one bus, each owner is
// pre-empted after its programmable quantum of acknowledged transfers.
module wrr_bus_arbiter
   import arb_pkg::*;
#(
   parameter int unsigned WW         = 4,
   parameter int unsigned DEF_WEIGHT = 4
) (
   input  logic          clk,
   input  logic          rst,
   wrr_bus_arbiter_if.slave bus,
   input  logic          cfg_we,
   input  logic [1:0]    cfg_sel,
   input  logic [WW-1:0] cfg_wdata
);

   state_e               state_q, state_d;
   logic [IDX_W-1:0]     last_q, last_d;
   logic [IDX_W-1:0]     gnt_q, gnt_d;
   logic [NUM_MST-1:0]   oh_q, oh_d;
   logic [WW-1:0]        cnt_q, cnt_d;
   logic [WW-1:0]        quant_q, quant_d;
   logic [WW-1:0]        weight_q [NUM_MST];

   logic [NUM_MST-1:0]   req_c;
   logic [IDX_W-1:0]     pick_last_c;
   logic                 pick_valid_c;
   logic [IDX_W-1:0]     pick_idx_c;
   logic [WW-1:0]        win_quant_c;
   logic                 owner_req_c;
   logic                 others_c;
   logic                 expire_c;

   assign req_c = {bus.cyc3, bus.cyc2, bus.cyc1, bus.cyc0};

   // In SWITCH the pointer update is bypassed so the new winner sees last = old owner.
   assign pick_last_c = (state_q == SWITCH) ? gnt_q : last_q;

   rr_pick u_pick (
      .req   (req_c),
      .last  (pick_last_c),
      .valid (pick_valid_c),
      .idx   (pick_idx_c)
   );

   assign win_quant_c = (weight_q[pick_idx_c] == '0) ? WW'(1) : weight_q[pick_idx_c];
   assign owner_req_c = req_c[gnt_q];
   assign others_c    = |(req_c & ~idx2oh(gnt_q));
   assign expire_c    = bus.ack && (cnt_q == quant_q - WW'(1));

   // Next-state and grant logic.
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      gnt_d   = gnt_q;
      oh_d    = oh_q;
      cnt_d   = cnt_q;
      quant_d = quant_q;
      unique case (state_q)
         IDLE: begin
            if (pick_valid_c) begin
               state_d = BUSY;
               gnt_d   = pick_idx_c;
               oh_d    = idx2oh(pick_idx_c);
               cnt_d   = '0;
               quant_d = win_quant_c;
            end
         end
         BUSY: begin
            if (!owner_req_c) begin
               state_d = SWITCH;
               oh_d    = '0;
            end else if (expire_c) begin
               if (others_c) begin
                  state_d = SWITCH;
                  oh_d    = '0;
               end else begin
                  cnt_d = '0;
               end
            end else if (bus.ack) begin
               cnt_d = cnt_q + WW'(1);
            end
         end
         SWITCH: begin
            last_d = gnt_q;
            if (pick_valid_c) begin
               state_d = BUSY;
               gnt_d   = pick_idx_c;
               oh_d    = idx2oh(pick_idx_c);
               cnt_d   = '0;
               quant_d = win_quant_c;
            end else begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            oh_d    = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         last_q  <= PTR_RST;
         gnt_q   <= '0;
         oh_q    <= '0;
         cnt_q   <= '0;
         quant_q <= WW'(DEF_WEIGHT);
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         gnt_q   <= gnt_d;
         oh_q    <= oh_d;
         cnt_q   <= cnt_d;
         quant_q <= quant_d;
      end
   end

   // Weight registers; new values only matter at the next grant.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_MST; i++) begin
            weight_q[i] <= WW'(DEF_WEIGHT);
         end
      end else if (cfg_we) begin
         weight_q[cfg_sel] <= cfg_wdata;
      end
   end

   assign bus.gnt    = gnt_q;
   assign bus.gnt0   = oh_q[0];
   assign bus.gnt1   = oh_q[1];
   assign bus.gnt2   = oh_q[2];
   assign bus.gnt3   = oh_q[3];
   assign bus.comcyc = (state_q == BUSY) && owner_req_c;

endmodule

// File: tb/tb_wrr_bus_arbiter.sv
// Directed scoreboard bench for wrr_bus_arbiter: the driver queues hand-computed
// expectations, a monitor compares them against the outputs after each edge.
module tb_wrr_bus_arbiter;

   typedef struct {
      logic [1:0] g;
      logic [3:0] oh;
      logic       com;
      string      tag;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cfg_we = 1'b0;
   logic [1:0] cfg_sel = 2'd0;
   logic [3:0] cfg_wdata = 4'd0;

   int n_vec  = 0;
   int n_miss = 0;
   exp_t exp_q[$];

   wrr_bus_arbiter_if bus_if ();

   wrr_bus_arbiter #(.WW(4), .DEF_WEIGHT(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus_if),
      .cfg_we    (cfg_we),
      .cfg_sel   (cfg_sel),
      .cfg_wdata (cfg_wdata)
   );

   always #5 clk = ~clk;

   task automatic push(input logic [1:0] g, input logic [3:0] oh, input logic com, input string tag);
      exp_t e;
      e.g = g; e.oh = oh; e.com = com; e.tag = tag;
      exp_q.push_back(e);
   endtask

   task automatic drive(input logic [3:0] cyc, input logic a);
      bus_if.cyc0 = cyc[0];
      bus_if.cyc1 = cyc[1];
      bus_if.cyc2 = cyc[2];
      bus_if.cyc3 = cyc[3];
      bus_if.ack  = a;
   endtask

   // One clock of stimulus plus the outputs expected right after that edge.
   task automatic step(input logic [3:0] cyc, input logic a, input logic we, input logic [1:0] sel,
                       input logic [3:0] wd, input logic [1:0] g, input logic [3:0] oh,
                       input logic com, input string tag);
      @(negedge clk);
      drive(cyc, a);
      cfg_we = we; cfg_sel = sel; cfg_wdata = wd;
      push(g, oh, com, tag);
   endtask

   task automatic run(input logic [3:0] cyc, input logic a, input int n, input logic [1:0] g,
                      input logic [3:0] oh, input logic com, input string tag);
      for (int i = 0; i < n; i++) step(cyc, a, 1'b0, 2'd0, 4'd0, g, oh, com, tag);
   endtask

   // Pulse reset between edges; expect zeros at once, then the given outputs after the next edge.
   task automatic areset(input logic [1:0] g, input logic [3:0] oh, input logic com, input string tag);
      @(negedge clk);
      cfg_we = 1'b0;
      bus_if.ack = 1'b0;
      push(2'd0, 4'b0000, 1'b0, {tag, "_async"});
      push(g, oh, com, {tag, "_post"});
      #1 rst = 1'b1;
      #2 rst = 1'b0;
   endtask

   // Monitor: after each clock edge or reset assertion, check the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk or posedge rst);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (bus_if.gnt !== e.g ||
                {bus_if.gnt3, bus_if.gnt2, bus_if.gnt1, bus_if.gnt0} !== e.oh ||
                bus_if.comcyc !== e.com) begin
               n_miss++;
               $display("FAIL %s: got gnt=%0d oh=%b comcyc=%b, want gnt=%0d oh=%b comcyc=%b",
                        e.tag, bus_if.gnt, {bus_if.gnt3, bus_if.gnt2, bus_if.gnt1, bus_if.gnt0},
                        bus_if.comcyc, e.g, e.oh, e.com);
            end
         end
      end
   end

   initial begin
      drive(4'b0000, 1'b0);
      step(4'b0000, 0, 0, 0, 0, 2'd0, 4'b0000, 0, "reset_state");
      @(negedge clk);
      rst = 1'b0;

      // Simultaneous requests from IDLE with last=3, then owner release.
      step(4'b1110, 0, 0, 0, 0, 2'd1, 4'b0010, 1, "t5_grant1");
      run (4'b1110, 1, 2,       2'd1, 4'b0010, 1, "t5_busy1");
      step(4'b1100, 0, 0, 0, 0, 2'd1, 4'b0000, 0, "t5_release");
      step(4'b1100, 0, 0, 0, 0, 2'd2, 4'b0100, 1, "t5_grant2");
      step(4'b0000, 0, 0, 0, 0, 2'd2, 4'b0000, 0, "t5_release2");
      step(4'b0000, 0, 0, 0, 0, 2'd2, 4'b0000, 0, "t5_idle");

      // Asynchronous reset mid-BUSY; cyc1 still high afterwards.
      step(4'b0010, 0, 0, 0, 0, 2'd1, 4'b0010, 1, "t1_grant1");
      areset(2'd1, 4'b0010, 1, "t1_rst");
      step(4'b0000, 0, 0, 0, 0, 2'd1, 4'b0000, 0, "t1_release");
      step(4'b0000, 0, 0, 0, 0, 2'd1, 4'b0000, 0, "t1_idle");

      // Lone requester keeps the bus across quantum expiries.
      step(4'b0001, 1, 0, 0, 0, 2'd0, 4'b0001, 1, "t2_grant0");
      run (4'b0001, 1, 10,      2'd0, 4'b0001, 1, "t2_hold");
      step(4'b0000, 0, 0, 0, 0, 2'd0, 4'b0000, 0, "t2_release");
      step(4'b0000, 0, 0, 0, 0, 2'd0, 4'b0000, 0, "t2_idle");

      // Two requesters with equal weights 4/4.
      areset(2'd0, 4'b0000, 0, "t3_rst");
      step(4'b0101, 1, 0, 0, 0, 2'd0, 4'b0001, 1, "t3_grant0");
      run (4'b0101, 1, 3,       2'd0, 4'b0001, 1, "t3_busy0");
      step(4'b0101, 1, 0, 0, 0, 2'd0, 4'b0000, 0, "t3_switch0");
      step(4'b0101, 1, 0, 0, 0, 2'd2, 4'b0100, 1, "t3_grant2");
      run (4'b0101, 1, 3,       2'd2, 4'b0100, 1, "t3_busy2");
      step(4'b0101, 1, 0, 0, 0, 2'd2, 4'b0000, 0, "t3_switch2");
      step(4'b0101, 1, 0, 0, 0, 2'd0, 4'b0001, 1, "t3_regrant0");
      run (4'b0101, 1, 3,       2'd0, 4'b0001, 1, "t3_busy0b");
      step(4'b0101, 1, 0, 0, 0, 2'd0, 4'b0000, 0, "t3_switch0b");
      step(4'b0000, 0, 0, 0, 0, 2'd0, 4'b0000, 0, "t3_idle");

      // Weights 1/3, then a weight change during master 2's tenure.
      step(4'b0000, 0, 1, 2'd0, 4'd1, 2'd0, 4'b0000, 0, "t4_cfg_w0");
      step(4'b0000, 0, 1, 2'd2, 4'd3, 2'd0, 4'b0000, 0, "t4_cfg_w2");
      step(4'b0101, 1, 0, 0, 0, 2'd2, 4'b0100, 1, "t4_grant2");
      run (4'b0101, 1, 2,       2'd2, 4'b0100, 1, "t4_busy2");
      step(4'b0101, 1, 0, 0, 0, 2'd2, 4'b0000, 0, "t4_switch2");
      step(4'b0101, 1, 0, 0, 0, 2'd0, 4'b0001, 1, "t4_grant0");
      step(4'b0101, 1, 0, 0, 0, 2'd0, 4'b0000, 0, "t4_switch0");
      step(4'b0101, 1, 0, 0, 0, 2'd2, 4'b0100, 1, "t4_grant2b");
      step(4'b0101, 1, 1, 2'd2, 4'd6, 2'd2, 4'b0100, 1, "t4_write6");
      step(4'b0101, 1, 0, 0, 0, 2'd2, 4'b0100, 1, "t4_oldq");
      step(4'b0101, 1, 0, 0, 0, 2'd2, 4'b0000, 0, "t4_switch_oldq");
      step(4'b0101, 1, 0, 0, 0, 2'd0, 4'b0001, 1, "t4_grant0b");
      step(4'b0101, 1, 0, 0, 0, 2'd0, 4'b0000, 0, "t4_switch0b");
      step(4'b0101, 1, 0, 0, 0, 2'd2, 4'b0100, 1, "t4_grant2_newq");
      run (4'b0101, 1, 5,       2'd2, 4'b0100, 1, "t4_busy_newq");
      step(4'b0101, 1, 0, 0, 0, 2'd2, 4'b0000, 0, "t4_switch_newq");
      step(4'b0000, 0, 0, 0, 0, 2'd2, 4'b0000, 0, "t4_idle");

      // Weight 0 behaves as quantum 1.
      areset(2'd0, 4'b0000, 0, "t6_rst");
      step(4'b0000, 0, 1, 2'd3, 4'd0, 2'd0, 4'b0000, 0, "t6_cfg_w3");
      step(4'b1001, 1, 0, 0, 0, 2'd0, 4'b0001, 1, "t6_grant0");
      run (4'b1001, 1, 3,       2'd0, 4'b0001, 1, "t6_busy0");
      step(4'b1001, 1, 0, 0, 0, 2'd0, 4'b0000, 0, "t6_switch0");
      step(4'b1001, 1, 0, 0, 0, 2'd3, 4'b1000, 1, "t6_grant3");
      step(4'b1001, 1, 0, 0, 0, 2'd3, 4'b0000, 0, "t6_switch3");
      step(4'b1001, 1, 0, 0, 0, 2'd0, 4'b0001, 1, "t6_grant0b");
      step(4'b1001, 0, 0, 0, 0, 2'd0, 4'b0001, 1, "t6_noack");
      run (4'b1001, 1, 3,       2'd0, 4'b0001, 1, "t6_busy0b");
      step(4'b1001, 1, 0, 0, 0, 2'd0, 4'b0000, 0, "t6_switch0b");
      step(4'b1001, 1, 0, 0, 0, 2'd3, 4'b1000, 1, "t6_grant3b");
      step(4'b1001, 1, 0, 0, 0, 2'd3, 4'b0000, 0, "t6_switch3b");
      step(4'b0000, 0, 0, 0, 0, 2'd3, 4'b0000, 0, "t6_idle");

      repeat (3) @(negedge clk);
      if (exp_q.size() != 0) begin
         n_vec++;
         n_miss++;
         $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/wrr_bus_arbiter.md
Name: wrr_bus_arbiter

Overview:
Weighted round-robin arbiter that shares one bus between four masters (cyc0..cyc3), with a programmable transfer quantum per master. It extends the existing 4-way round-robin arbiter. A master holding the bus is pre-empted after its quantum of acknowledged transfers whenever another master is waiting. It sits between the master request lines and the shared slave bus, and drives the one-hot grants, the encoded owner index and the combined cycle (comcyc).

Parameters:
WW, 4, width of each per-master weight (quantum) register
DEF_WEIGHT, 4, reset value of all four weight registers (must be 1..2^WW-1)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-high
cyc0  input  1  master 0 bus request; held high for the whole bus cycle
cyc1  input  1  master 1 bus request
cyc2  input  1  master 2 bus request
cyc3  input  1  master 3 bus request
ack  input  1  slave transfer acknowledge for the current owner; one transfer per cycle high
cfg_we  input  1  weight register write strobe
cfg_sel  input  2  index of the weight register to write
cfg_wdata  input  WW  weight value to write
gnt  output  2  encoded index of the current or most recent owner
gnt0  output  1  one-hot grant, master 0
gnt1  output  1  one-hot grant, master 1
gnt2  output  1  one-hot grant, master 2
gnt3  output  1  one-hot grant, master 3
comcyc  output  1  combined bus cycle to the slave side

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high. It clears state immediately, with no clock needed.
- Reset values:
  - gnt=2'b00; gnt0..gnt3=0; comcyc=0; state=IDLE.
  - Round-robin pointer last=3, so master 0 is highest priority first.
  - Transfer counter cnt=0; all weights=DEF_WEIGHT.
- State machine: IDLE, BUSY, SWITCH.
- Pick function: the first asserted cyc in rotating order last+1, last+2, last+3, last (mod 4).
- IDLE:
  - If any cyc is high at edge k, the winner is registered at edge k. The state goes to BUSY, and gnt / gntN are visible after edge k (one-cycle grant latency).
  - cnt is cleared to 0. The quantum q is latched as weight[winner], with 0 treated as 1.
- BUSY:
  - Exactly one gntN is high, and it matches gnt.
  - comcyc = cyc[gnt] while BUSY; comcyc is 0 in all other states.
  - Each cycle with ack=1 increments cnt.
  - Owner release: if cyc[gnt] falls, go to SWITCH at the next edge. Any ack in that cycle is ignored.
  - Quantum expiry: when ack=1 and cnt==q-1, the quantum is exhausted.
    - If any other cyc is high, go to SWITCH (pre-emption).
    - Otherwise clear cnt to 0 and stay in BUSY, keeping the grant.
  - Release and expiry in the same cycle: go to SWITCH.
- SWITCH:
  - Exactly one cycle. All gntN=0 and comcyc=0. gnt keeps the previous owner's index.
  - The pointer is updated: last=gnt.
  - If any cyc is high, pick a winner using the new last, go directly to BUSY with a fresh cnt and q. Otherwise go to IDLE.
  - A pre-empted master that still holds cyc competes normally and wins again only if no other master is requesting.
- Weight writes:
  - When cfg_we=1, weight[cfg_sel] <= cfg_wdata at the edge.
  - The change takes effect at the next grant. The quantum q of the current owner is unaffected.
  - Writes are accepted in every state.
- No master is granted while its cyc is low. A request that drops in IDLE before it is sampled is never granted.
- Counter width is WW bits. cnt never exceeds q-1, so it cannot overflow.
- Reset mid-operation: all outputs drop to their reset values asynchronously. The weights return to DEF_WEIGHT.

Decomposition:
- Package arb_pkg:
  - NUM_MST=4
  - state enum {IDLE, BUSY, SWITCH}
  - constant PTR_RST=2'd3
- Sub-module rr_pick: a combinational rotate-priority picker. Inputs: req[3:0] and last[1:0]. Outputs: valid and idx[1:0]. Instantiated once in wrr_bus_arbiter.

Test Plan:
1. Assert rst mid-BUSY with cyc1 high → gnt/gntN/comcyc go to 0 immediately, without a clock edge. After release, cyc1 is still high → gnt1=1 one edge later, gnt=2'b01.
2. Only cyc0=1 with continuous ack, DEF_WEIGHT=4 → gnt0 is held indefinitely with no SWITCH cycle. cnt wraps 0→3→0.
3. cyc0 and cyc2 both held high with continuous ack, weights 4/4 → grant sequence: 4 acks to master 0, one SWITCH cycle (all gntN=0), 4 acks to master 2, SWITCH, master 0, and so on.
4. cfg writes weight0=1 and weight2=3; then cyc0 and cyc2 held high with ack → pattern of 1 transfer for master 0 and 3 transfers for master 2, each followed by a SWITCH cycle. A write to weight2=6 during master 2's tenure applies only from master 2's next grant.
5. cyc1, cyc2 and cyc3 all rise in the same cycle from IDLE after reset (last=3) → master 1 granted first. Master 1 drops cyc1 after 2 acks → SWITCH, then master 2 granted.
6. cfg writes weight3=0 → master 3 gets a quantum of 1. cyc3 and cyc0 held high with ack → alternation of 1 transfer for master 3 and 4 transfers for master 0. comcyc follows cyc[gnt] and is 0 in every SWITCH cycle.
